// File: rtl/soc_simple_pll_ctrl_pkg.sv
// Shared types and widths for the soc_simple PLL reset/lock sequencer.
package soc_simple_pll_ctrl_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned RETRY_W = 4;
    localparam int unsigned LOSS_W  = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_ctrl_state_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/soc_simple_sync2.sv
// Generic two-flop synchronizer, synchronously cleared by rst_n.
module soc_simple_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/soc_simple_pll_rst_ctrl.sv
// PLL reset and lock sequencer: drives pll_rst, qualifies lock, releases sys_rst_n.
// Optional loss counter output enabled by SOC_PLL_RST_CTRL_LOSS_CNT_EN.
module soc_simple_pll_rst_ctrl
    import soc_simple_pll_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic               relock_req,
    output logic               pll_rst,
    output logic               sys_rst_n,
    output logic               ready,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [STATE_W-1:0] state
`ifdef SOC_PLL_RST_CTRL_LOSS_CNT_EN
    ,
    output logic [LOSS_W-1:0]  loss_cnt
`endif
);

    localparam int unsigned CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

    pll_ctrl_state_t    state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               locked_s;

    soc_simple_sync2 u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    // Next-state and retry bookkeeping
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        case (state_q)
            ST_RESET_PLL: begin
                if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TO_LAST) begin
                    retry_d = (retry_q < RETRY_MAX) ? retry_q + RETRY_W'(1) : retry_q;
                    state_d = (retry_d == RETRY_MAX) ? ST_FAIL : ST_RESET_PLL;
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    retry_d = '0;
                end
            end
            ST_RUN: begin
                if (!locked_s || relock_req) state_d = ST_RESET_PLL;
            end
            ST_FAIL: begin
                if (relock_req) begin
                    state_d = ST_RESET_PLL;
                    retry_d = '0;
                end
            end
            default: state_d = ST_RESET_PLL;
        endcase
    end

    // State, shared counter and outputs decoded from the next state
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_q   <= ST_RESET_PLL;
            cnt_q     <= '0;
            retry_q   <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            retry_q   <= retry_d;
            pll_rst   <= (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
            sys_rst_n <= (state_d == ST_RUN);
            ready     <= (state_d == ST_RUN);
            fail      <= (state_d == ST_FAIL);
        end
    end

    assign retry_cnt = retry_q;
    assign state     = state_q;

`ifdef SOC_PLL_RST_CTRL_LOSS_CNT_EN
    logic              loss_inc;
    logic [LOSS_W-1:0] loss_q;

    // Only lock-loss exits from RUN are counted; software relocks are not
    assign loss_inc = (state_q == ST_RUN) && !locked_s;

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            loss_q <= '0;
        end else if (loss_inc && (loss_q != '1)) begin
            loss_q <= loss_q + LOSS_W'(1);
        end
    end

    assign loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_soc_simple_pll_rst_ctrl.sv
// Scoreboard bench for soc_simple_pll_rst_ctrl: directed bring-up scenarios plus random lock/relock traffic.
module tb_soc_simple_pll_rst_ctrl;

    localparam int RST_CYCLES   = 4;
    localparam int LOCK_TIMEOUT = 32;
    localparam int LOCK_STABLE  = 8;
    localparam int MAX_RETRY    = 2;

    localparam int PH_RESET  = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_STABLE = 2;
    localparam int PH_RUN    = 3;
    localparam int PH_FAIL   = 4;

    logic       refclk     = 1'b0;
    logic       rst_n      = 1'b0;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst, sys_rst_n, ready, fail;
    logic [3:0] retry_cnt;
    logic [2:0] state;
`ifdef SOC_PLL_RST_CTRL_LOSS_CNT_EN
    logic [7:0] loss_cnt;
`endif

    soc_simple_pll_rst_ctrl #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .LOCK_STABLE  (LOCK_STABLE),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt),
        .state      (state)
`ifdef SOC_PLL_RST_CTRL_LOSS_CNT_EN
        ,
        .loss_cnt   (loss_cnt)
`endif
    );

    always #10 refclk = ~refclk;

    typedef struct {
        int pll_rst;
        int sys_rst_n;
        int ready;
        int fail;
        int retry;
        int phase;
        int loss;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase plus time spent in it; lock seen two samples late
    int m_phase = PH_RESET;
    int m_time  = 0;
    int m_retry = 0;
    int m_loss  = 0;
    int lk_hist[$] = '{0, 0};

    function automatic void model_step(input int ls, input int rq);
        int nxt;
        nxt = m_phase;
        if (m_phase == PH_RESET) begin
            if (m_time + 1 >= RST_CYCLES) nxt = PH_WAIT;
        end else if (m_phase == PH_WAIT) begin
            if (ls != 0) begin
                nxt = PH_STABLE;
            end else if (m_time + 1 >= LOCK_TIMEOUT) begin
                m_retry = (m_retry + 1 > MAX_RETRY) ? MAX_RETRY : m_retry + 1;
                nxt = (m_retry == MAX_RETRY) ? PH_FAIL : PH_RESET;
            end
        end else if (m_phase == PH_STABLE) begin
            if (ls == 0) begin
                nxt = PH_WAIT;
            end else if (m_time + 1 >= LOCK_STABLE) begin
                nxt = PH_RUN;
                m_retry = 0;
            end
        end else if (m_phase == PH_RUN) begin
            if (ls == 0 || rq != 0) begin
                nxt = PH_RESET;
                if (ls == 0 && m_loss < 255) m_loss++;
            end
        end else begin
            if (rq != 0) begin
                nxt = PH_RESET;
                m_retry = 0;
            end
        end
        m_time  = (nxt == m_phase) ? m_time + 1 : 0;
        m_phase = nxt;
    endfunction

    always @(posedge refclk) begin : model_p
        exp_t e;
        if (!rst_n) begin
            m_phase = PH_RESET;
            m_time  = 0;
            m_retry = 0;
            m_loss  = 0;
            lk_hist = '{0, 0};
        end else begin
            model_step(lk_hist[0], int'(relock_req));
            void'(lk_hist.pop_front());
            lk_hist.push_back(int'(pll_locked));
        end
        e.pll_rst   = (m_phase == PH_RESET || m_phase == PH_FAIL) ? 1 : 0;
        e.sys_rst_n = (m_phase == PH_RUN) ? 1 : 0;
        e.ready     = (m_phase == PH_RUN) ? 1 : 0;
        e.fail      = (m_phase == PH_FAIL) ? 1 : 0;
        e.retry     = m_retry;
        e.phase     = m_phase;
        e.loss      = m_loss;
        exp_q.push_back(e);
    end

    // Monitor: the DUT presents a new output set on every edge
    always @(posedge refclk) begin : monitor_p
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk("pll_rst",   int'(pll_rst),   e.pll_rst);
            chk("sys_rst_n", int'(sys_rst_n), e.sys_rst_n);
            chk("ready",     int'(ready),     e.ready);
            chk("fail",      int'(fail),      e.fail);
            chk("retry_cnt", int'(retry_cnt), e.retry);
            chk("state",     int'(state),     e.phase);
`ifdef SOC_PLL_RST_CTRL_LOSS_CNT_EN
            chk("loss_cnt",  int'(loss_cnt),  e.loss);
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge refclk);
    endtask

    // Counts edges (the first edge counted as 1) until a condition holds, bounded
    task automatic edges_until(input int which, input int limit, output int n);
        logic hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < limit) begin
            @(posedge refclk);
            #1;
            n++;
            case (which)
                0:       hit = ready;
                1:       hit = !sys_rst_n;
                2:       hit = fail;
                default: hit = (state == 3'(which - 10));
            endcase
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pll_rst"},   int'(pll_rst),   1);
        chk({tag, "_sys_rst_n"}, int'(sys_rst_n), 0);
        chk({tag, "_ready"},     int'(ready),     0);
        chk({tag, "_fail"},      int'(fail),      0);
        chk({tag, "_state"},     int'(state),     PH_RESET);
        chk({tag, "_retry"},     int'(retry_cnt), 0);
    endtask

    initial begin
        int n;
        cyc(3);
        chk_reset_outputs("por");

        // Clean bring-up: lock arrives 10 cycles after reset release
        rst_n = 1'b1;
        cyc(10);
        pll_locked = 1'b1;
        edges_until(0, 100, n);
        chk("bringup_release_edges", n, 2 + 1 + LOCK_STABLE);
        chk("bringup_retry", int'(retry_cnt), 0);

        // Lock loss in RUN
        @(negedge refclk);
        pll_locked = 1'b0;
        edges_until(1, 20, n);
        chk("lossrun_edges", n, 3);
        chk("lossrun_pll_rst", int'(pll_rst), 1);

        // Short lock, one-cycle glitch, re-lock
        cyc(8);
        pll_locked = 1'b1;
        cyc(5);
        pll_locked = 1'b0;
        cyc(1);
        pll_locked = 1'b1;
        edges_until(0, 100, n);
        chk("glitch_release_edges", n, 11);
        chk("glitch_retry", int'(retry_cnt), 0);

        // No lock at all: two timeouts then FAIL
        @(negedge refclk);
        pll_locked = 1'b0;
        edges_until(2, 300, n);
        chk("timeout_fail", int'(fail), 1);
        chk("timeout_retry", int'(retry_cnt), MAX_RETRY);
        cyc(20);
        chk("fail_held", int'(fail), 1);
        chk("fail_pll_rst", int'(pll_rst), 1);
        relock_req = 1'b1;
        cyc(1);
        relock_req = 1'b0;
        chk("relock_state", int'(state), PH_RESET);
        chk("relock_retry", int'(retry_cnt), 0);
        pll_locked = 1'b1;
        edges_until(0, 100, n);
        chk("relock_ready", int'(ready), 1);

        // Relock request coincides with synchronized lock loss
        @(negedge refclk);
        pll_locked = 1'b0;
        cyc(2);
        relock_req = 1'b1;
        cyc(1);
        relock_req = 1'b0;
        chk("simul_state", int'(state), PH_RESET);
`ifdef SOC_PLL_RST_CTRL_LOSS_CNT_EN
        chk("simul_loss_cnt", int'(loss_cnt), 3);
`endif

        // rst_n during STABLE
        pll_locked = 1'b1;
        edges_until(10 + PH_STABLE, 100, n);
        chk("reach_stable", int'(state), PH_STABLE);
        @(negedge refclk);
        rst_n = 1'b0;
        @(posedge refclk);
        #1;
        chk_reset_outputs("rst_stable");
        @(negedge refclk);
        rst_n = 1'b1;

        // rst_n during RUN
        edges_until(0, 100, n);
        chk("reach_run", int'(ready), 1);
        @(negedge refclk);
        rst_n = 1'b0;
        @(posedge refclk);
        #1;
        chk_reset_outputs("rst_run");
`ifdef SOC_PLL_RST_CTRL_LOSS_CNT_EN
        chk("rst_run_loss_cnt", int'(loss_cnt), 0);
`endif
        @(negedge refclk);
        rst_n = 1'b1;

        // Random lock flapping, relock pulses and occasional resets
        for (int i = 0; i < 4000; i++) begin
            @(negedge refclk);
            relock_req = 1'b0;
            rst_n = 1'b1;
            if (pll_locked ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 19) == 0))
                pll_locked = ~pll_locked;
            if ($urandom_range(0, 63) == 0) relock_req = 1'b1;
            if ($urandom_range(0, 799) == 0) rst_n = 1'b0;
        end
        @(negedge refclk);
        relock_req = 1'b0;
        rst_n = 1'b1;
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/soc_simple_pll_rst_ctrl.md
# soc_simple_pll_rst_ctrl

Reset and lock sequencer for the soc_simple 50→150 MHz PLL. Runs on the free-running 50 MHz reference clock. Drives the PLL reset, qualifies the PLL locked flag, and releases the SoC system reset only after a stable lock. On lock loss or software request it re-sequences the PLL, and it reports a hard failure after repeated lock timeouts.

## Interface
- RST_CYCLES, 16: cycles pll_rst is held high per attempt (≥1)
- LOCK_TIMEOUT, 65536: max cycles in WAIT_LOCK before an attempt fails (≥2)
- LOCK_STABLE, 1024: consecutive synchronized-lock cycles required before release (≥1)
- MAX_RETRY, 3: failed attempts allowed before FAIL (1..15)
- refclk  in  1  50 MHz reference clock; the only clock
- rst_n  in  1  synchronous, active-low reset
- pll_locked  in  1  PLL locked flag, asynchronous to refclk
- relock_req  in  1  single-cycle request to re-sequence the PLL
- pll_rst  out  1  PLL reset, active high
- sys_rst_n  out  1  SoC reset, active low, refclk domain
- ready  out  1  high while in RUN
- fail  out  1  high while in FAIL
- retry_cnt  out  4  failed attempts since last RUN or FAIL exit
- state  out  3  current FSM state, for debug

## Operation
- pll_locked passes through a 2-flop synchronizer to give locked_s (2-cycle latency). The FSM uses only locked_s.
- States: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4. One counter cnt is shared by all states and cleared on every state change.
- RESET_PLL: pll_rst=1. After RST_CYCLES cycles, go to WAIT_LOCK.
- WAIT_LOCK: pll_rst=0.
  - locked_s=1: go to STABLE.
  - cnt reaches LOCK_TIMEOUT-1 with no lock: retry_cnt increments. If the new value equals MAX_RETRY, go to FAIL; otherwise go to RESET_PLL.
- STABLE:
  - locked_s=0: go back to WAIT_LOCK. No retry is counted and the timeout restarts.
  - LOCK_STABLE consecutive cycles of locked_s=1: go to RUN and clear retry_cnt.
- RUN:
  - locked_s=0 or relock_req=1: go to RESET_PLL.
  - If both occur in the same cycle, there is exactly one transition.
- FAIL:
  - pll_rst=1 and sys_rst_n=0, held indefinitely.
  - relock_req=1: go to RESET_PLL and clear retry_cnt.
- relock_req is ignored in RESET_PLL, WAIT_LOCK and STABLE.
- Output decode:
  - sys_rst_n=ready=(state==RUN)
  - fail=(state==FAIL)
  - pll_rst=(state==RESET_PLL or FAIL)
- Counters never wrap. cnt width is $clog2 of the largest of RST_CYCLES, LOCK_TIMEOUT and LOCK_STABLE. retry_cnt saturates at MAX_RETRY.

## Timing
- Reset (rst_n=0 sampled at an edge) sets:
  - state=RESET_PLL, cnt=0, retry_cnt=0
  - pll_rst=1, sys_rst_n=0, ready=0, fail=0
  - both synchronizer flops=0
- A reset asserted mid-operation takes effect at the next edge from any state. sys_rst_n drops on that same edge.
- All outputs are registered and change on the same edge as state.
- Lock-to-release latency, counted from the first refclk edge that samples pll_locked=1: 2 cycles of synchronizer, plus 1 cycle to enter STABLE, plus LOCK_STABLE cycles.
- Lock loss in RUN: sys_rst_n falls 3 edges after the first edge that samples pll_locked=0. pll_rst rises on that same edge.
- Minimum pll_rst high width: RST_CYCLES cycles.

## Configuration
- SOC_PLL_RST_CTRL_LOSS_CNT_EN
  - Defined: adds output loss_cnt [7:0]. It increments, saturating at 255, on every RUN→RESET_PLL transition caused by locked_s=0 (relock_req exits are not counted). Cleared only by rst_n.
  - Undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Package soc_simple_pll_ctrl_pkg holds:
  - state enum pll_ctrl_state_t (3 bits, encodings as above)
  - STATE_W=3, RETRY_W=4, LOSS_W=8
- Sub-module soc_simple_sync2: generic 2-flop synchronizer, reset to 0 by rst_n. Used for pll_locked.
- The FSM and counters live in the top module.

## Test plan
Parameters for all cases: RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, MAX_RETRY=2.
- Clean bring-up: release rst_n, raise pll_locked at cycle 10 → pll_rst high for 4 cycles, then low. sys_rst_n rises 11 cycles after lock is sampled. retry_cnt=0.
- Lock glitch in STABLE: lock for 5 cycles, drop for 1 cycle, re-lock → state returns to WAIT_LOCK, sys_rst_n stays 0, release occurs 11 cycles after the re-lock. retry_cnt=0.
- Timeout to FAIL: keep pll_locked=0 → two 32-cycle WAIT_LOCK windows, retry_cnt goes 1 then 2, then fail=1 and pll_rst=1 held. Pulse relock_req → RESET_PLL, retry_cnt=0.
- Lock loss in RUN: drop pll_locked → sys_rst_n=0 and pll_rst=1 three edges later, then a full re-sequence. With the macro defined, loss_cnt=1.
- Simultaneous relock_req and lock loss in RUN → single entry into RESET_PLL. loss_cnt increments by 1.
- rst_n asserted during STABLE and during RUN → all outputs return to their reset values at the next edge.
